// File: rtl/scarv_cop_issue.sv
// CPU-side initiator of the CPU-to-COP instruction interface: issues one
// instruction at a time over req/ack, collects the response, and returns it to writeback.
module scarv_cop_issue #(
  parameter int unsigned TIMEOUT_CYCLES = 1023,
  parameter logic [3:0]  CUSTOM_MASK    = 4'b1111
) (
  input  logic        g_clk,
  input  logic        g_resetn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_encoded,
  input  logic [31:0] in_rs1,
  output logic        cpu_insn_req,
  input  logic        cpu_insn_ack,
  output logic [31:0] cpu_insn_enc,
  output logic [31:0] cpu_rs1,
  input  logic        cop_insn_rsp,
  output logic        cop_insn_ack,
  input  logic [2:0]  cop_insn_result,
  input  logic        cop_wen,
  input  logic [4:0]  cop_waddr,
  input  logic [31:0] cop_wdata,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic        wb_wen,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic [2:0]  wb_result
);

  localparam int unsigned       CNT_W       = 16;
  localparam logic [CNT_W-1:0]  CNT_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX     = {CNT_W{1'b1}};
  localparam logic [2:0]        RES_TIMEOUT = 3'b111;
  localparam logic [2:0]        RES_ILLEGAL = 3'b110;

  typedef enum logic [1:0] {IDLE, REQ, RSP, WB} state_t;

  state_t             r_state, w_state_nxt;
  logic               r_stale, w_stale_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic               r_req, w_req_nxt;
  logic [31:0]        r_enc, w_enc_nxt;
  logic [31:0]        r_rs1, w_rs1_nxt;
  logic               r_wen, w_wen_nxt;
  logic [4:0]         r_rd, w_rd_nxt;
  logic [31:0]        r_data, w_data_nxt;
  logic [2:0]         r_result, w_result_nxt;

  logic               w_is_cop;
  logic               w_cnt_hit;
  logic [CNT_W-1:0]   w_cnt_inc;

  // Custom-0..3 opcodes, individually enabled by CUSTOM_MASK
  always_comb begin
    w_is_cop = 1'b0;
    case (in_encoded[6:0])
      7'h0B:   w_is_cop = CUSTOM_MASK[0];
      7'h2B:   w_is_cop = CUSTOM_MASK[1];
      7'h5B:   w_is_cop = CUSTOM_MASK[2];
      7'h7B:   w_is_cop = CUSTOM_MASK[3];
      default: w_is_cop = 1'b0;
    endcase
  end

  assign w_cnt_hit = (r_cnt >= CNT_LAST);
  assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);

  assign in_ready     = (r_state == IDLE) && !r_stale;
  assign cop_insn_ack = (r_state == RSP) || ((r_state == IDLE) && r_stale);
  assign wb_valid     = (r_state == WB);

  assign cpu_insn_req = r_req;
  assign cpu_insn_enc = r_enc;
  assign cpu_rs1      = r_rs1;
  assign wb_wen       = r_wen;
  assign wb_rd        = r_rd;
  assign wb_data      = r_data;
  assign wb_result    = r_result;

  always_comb begin
    w_state_nxt  = r_state;
    w_stale_nxt  = r_stale;
    w_cnt_nxt    = r_cnt;
    w_req_nxt    = r_req;
    w_enc_nxt    = r_enc;
    w_rs1_nxt    = r_rs1;
    w_wen_nxt    = r_wen;
    w_rd_nxt     = r_rd;
    w_data_nxt   = r_data;
    w_result_nxt = r_result;
    case (r_state)
      IDLE: begin
        if (r_stale) begin
          // Swallow the late response of a timed-out instruction
          if (cop_insn_rsp) w_stale_nxt = 1'b0;
        end else if (in_valid) begin
          if (w_is_cop) begin
            w_req_nxt   = 1'b1;
            w_enc_nxt   = in_encoded;
            w_rs1_nxt   = in_rs1;
            w_cnt_nxt   = '0;
            w_state_nxt = REQ;
          end else begin
            w_result_nxt = RES_ILLEGAL;
            w_wen_nxt    = 1'b0;
            w_rd_nxt     = '0;
            w_data_nxt   = '0;
            w_state_nxt  = WB;
          end
        end
      end
      REQ: begin
        if (cpu_insn_ack) begin
          w_req_nxt   = 1'b0;
          w_cnt_nxt   = '0;
          w_state_nxt = RSP;
        end else if (w_cnt_hit) begin
          w_req_nxt    = 1'b0;
          w_result_nxt = RES_TIMEOUT;
          w_wen_nxt    = 1'b0;
          w_rd_nxt     = '0;
          w_data_nxt   = '0;
          w_state_nxt  = WB;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      RSP: begin
        if (cop_insn_rsp) begin
          w_result_nxt = cop_insn_result;
          w_wen_nxt    = cop_wen;
          w_rd_nxt     = cop_waddr;
          w_data_nxt   = cop_wen ? cop_wdata : 32'h0;
          w_state_nxt  = WB;
        end else if (w_cnt_hit) begin
          w_result_nxt = RES_TIMEOUT;
          w_wen_nxt    = 1'b0;
          w_rd_nxt     = '0;
          w_data_nxt   = '0;
          w_stale_nxt  = 1'b1;
          w_state_nxt  = WB;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      WB: begin
        if (wb_ready) begin
          w_result_nxt = '0;
          w_wen_nxt    = 1'b0;
          w_rd_nxt     = '0;
          w_data_nxt   = '0;
          w_state_nxt  = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      r_state  <= IDLE;
      r_stale  <= 1'b0;
      r_cnt    <= '0;
      r_req    <= 1'b0;
      r_enc    <= '0;
      r_rs1    <= '0;
      r_wen    <= 1'b0;
      r_rd     <= '0;
      r_data   <= '0;
      r_result <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_stale  <= w_stale_nxt;
      r_cnt    <= w_cnt_nxt;
      r_req    <= w_req_nxt;
      r_enc    <= w_enc_nxt;
      r_rs1    <= w_rs1_nxt;
      r_wen    <= w_wen_nxt;
      r_rd     <= w_rd_nxt;
      r_data   <= w_data_nxt;
      r_result <= w_result_nxt;
    end
  end

endmodule

// File: tb/tb_scarv_cop_issue.sv
// Bench for scarv_cop_issue: a reactive COP model driven by per-transaction
// delays, checked against outcomes predicted from the handshake/timeout rules.
module tb_scarv_cop_issue;

  localparam int unsigned T    = 8;
  localparam logic [3:0]  MASK = 4'b1011;

  logic        g_clk, g_resetn;
  logic        in_valid, in_ready;
  logic [31:0] in_encoded, in_rs1;
  logic        cpu_insn_req, cpu_insn_ack;
  logic [31:0] cpu_insn_enc, cpu_rs1;
  logic        cop_insn_rsp, cop_insn_ack;
  logic [2:0]  cop_insn_result;
  logic        cop_wen;
  logic [4:0]  cop_waddr;
  logic [31:0] cop_wdata;
  logic        wb_valid, wb_ready, wb_wen;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [2:0]  wb_result;

  scarv_cop_issue #(.TIMEOUT_CYCLES(T), .CUSTOM_MASK(MASK)) dut (
    .g_clk(g_clk), .g_resetn(g_resetn),
    .in_valid(in_valid), .in_ready(in_ready), .in_encoded(in_encoded), .in_rs1(in_rs1),
    .cpu_insn_req(cpu_insn_req), .cpu_insn_ack(cpu_insn_ack),
    .cpu_insn_enc(cpu_insn_enc), .cpu_rs1(cpu_rs1),
    .cop_insn_rsp(cop_insn_rsp), .cop_insn_ack(cop_insn_ack),
    .cop_insn_result(cop_insn_result), .cop_wen(cop_wen),
    .cop_waddr(cop_waddr), .cop_wdata(cop_wdata),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_wen(wb_wen),
    .wb_rd(wb_rd), .wb_data(wb_data), .wb_result(wb_result)
  );

  initial g_clk = 1'b0;
  always #5 g_clk = ~g_clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic bit model_is_cop(input logic [6:0] op);
    logic [6:0] ops [4];
    ops[0] = 7'h0B; ops[1] = 7'h2B; ops[2] = 7'h5B; ops[3] = 7'h7B;
    for (int i = 0; i < 4; i++)
      if (op == ops[i] && MASK[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic randomize_cop_payload();
    cop_insn_result = 3'($urandom);
    cop_wen         = 1'($urandom);
    cop_waddr       = 5'($urandom);
    cop_wdata       = $urandom;
  endtask

  // One instruction: ack_dly/rsp_dly are cycles the COP waits before acking/responding
  task automatic run_txn(input logic [31:0] enc, input logic [31:0] rs1,
                         input int ack_dly, input int rsp_dly, input int wb_dly,
                         input logic [2:0] res, input logic wen,
                         input logic [4:0] wa, input logic [31:0] wd);
    bit legal, acked, responded, stale, got, ack_done, ack_fired;
    int exp_lat, lat, req_cyc, rsp_cyc, req_seen, k;
    logic [2:0] e_res;
    logic e_wen;
    logic [4:0] e_rd;
    logic [31:0] e_data;
    legal     = model_is_cop(enc[6:0]);
    acked     = legal && (ack_dly < int'(T));
    responded = acked && (rsp_dly < int'(T));
    stale     = acked && !responded;
    if (!legal)          begin exp_lat = 1;                     e_res = 3'b110; end
    else if (!acked)     begin exp_lat = 1 + int'(T);           e_res = 3'b111; end
    else if (!responded) begin exp_lat = 2 + ack_dly + int'(T); e_res = 3'b111; end
    else                 begin exp_lat = 3 + ack_dly + rsp_dly; e_res = res;    end
    e_wen  = responded ? wen : 1'b0;
    e_rd   = responded ? wa : 5'd0;
    e_data = (responded && wen) ? wd : 32'h0;

    @(negedge g_clk);
    chk("in_ready_idle", 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_encoded = enc; in_rs1 = rs1;
    lat = 0; got = 0; ack_done = 0; ack_fired = 0; req_cyc = 0; rsp_cyc = 0; req_seen = 0;
    while (!got && lat < 200) begin
      @(negedge g_clk);
      lat++;
      in_valid = 1'b0; in_encoded = $urandom; in_rs1 = $urandom;
      cpu_insn_ack = 1'b0; cop_insn_rsp = 1'b0;
      randomize_cop_payload();
      if (ack_fired) begin
        chk("req_drop_after_ack", 32'(cpu_insn_req), 32'd0);
        ack_fired = 0;
      end
      if (wb_valid) got = 1;
      else if (cpu_insn_req) begin
        req_seen++;
        chk("enc_hold", cpu_insn_enc, enc);
        chk("rs1_hold", cpu_rs1, rs1);
        if (req_cyc == ack_dly) begin
          cpu_insn_ack = 1'b1; ack_done = 1; ack_fired = 1;
        end
        req_cyc++;
      end else if (ack_done && cop_insn_ack) begin
        if (rsp_cyc == rsp_dly) begin
          cop_insn_rsp = 1'b1; cop_insn_result = res;
          cop_wen = wen; cop_waddr = wa; cop_wdata = wd;
        end
        rsp_cyc++;
      end
    end
    chk("wb_latency", 32'(lat), 32'(exp_lat));
    chk("req_asserted", 32'(req_seen > 0), 32'(legal));
    chk("wb_result", 32'(wb_result), 32'(e_res));
    chk("wb_wen", 32'(wb_wen), 32'(e_wen));
    chk("wb_rd", 32'(wb_rd), 32'(e_rd));
    chk("wb_data", wb_data, e_data);
    chk("in_ready_wb", 32'(in_ready), 32'd0);
    for (int i = 0; i < wb_dly; i++) begin
      @(negedge g_clk);
      chk("wb_valid_hold", 32'(wb_valid), 32'd1);
      chk("wb_data_hold", wb_data, e_data);
      chk("wb_result_hold", 32'(wb_result), 32'(e_res));
      chk("in_ready_hold", 32'(in_ready), 32'd0);
    end
    wb_ready = 1'b1;
    @(negedge g_clk);
    wb_ready = 1'b0;
    chk("wb_valid_clear", 32'(wb_valid), 32'd0);
    chk("wb_payload_clear", {wb_data[28:0], wb_result}, 32'd0);
    chk("stale_in_ready", 32'(in_ready), stale ? 32'd0 : 32'd1);
    chk("stale_cop_ack", 32'(cop_insn_ack), stale ? 32'd1 : 32'd0);
    if (stale) begin
      k = $urandom_range(0, 3);
      for (int i = 0; i < k; i++) begin
        @(negedge g_clk);
        chk("stale_wait_ready", 32'(in_ready), 32'd0);
      end
      cop_insn_rsp = 1'b1; randomize_cop_payload(); cop_wen = 1'b1;
      @(negedge g_clk);
      cop_insn_rsp = 1'b0;
      chk("drain_in_ready", 32'(in_ready), 32'd1);
      chk("drain_no_wb", 32'(wb_valid), 32'd0);
      @(negedge g_clk);
      chk("drain_no_wb2", 32'(wb_valid), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    logic [6:0]  op;
    g_resetn = 1'b0; in_valid = 1'b0; in_encoded = '0; in_rs1 = '0;
    cpu_insn_ack = 1'b0; cop_insn_rsp = 1'b0; wb_ready = 1'b0;
    cop_insn_result = '0; cop_wen = 1'b0; cop_waddr = '0; cop_wdata = '0;
    #1;
    chk("rst_req", 32'(cpu_insn_req), 32'd0);
    chk("rst_enc", cpu_insn_enc, 32'd0);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_cop_ack", 32'(cop_insn_ack), 32'd0);
    repeat (2) @(negedge g_clk);
    g_resetn = 1'b1;

    run_txn(32'h0000_002B, 32'h1234, 0, 0, 0, 3'd0, 1'b1, 5'd5, 32'hDEAD_BEEF);
    run_txn(32'h0000_0033, 32'h55, 0, 0, 0, 3'd0, 1'b1, 5'd1, 32'h1);
    run_txn(32'h0000_107B, 32'hCAFE, 5, 1, 0, 3'd2, 1'b1, 5'd9, 32'h1111);
    run_txn(32'h0000_200B, 32'h77, 0, 100, 1, 3'd0, 1'b1, 5'd3, 32'h3);
    run_txn(32'h0000_007B, 32'h88, 100, 0, 0, 3'd0, 1'b1, 5'd3, 32'h3);
    run_txn(32'h0000_002B, 32'h99, 0, 0, 4, 3'd0, 1'b0, 5'd3, 32'hA5A5_A5A5);
    run_txn(32'h0000_005B, 32'h66, 0, 0, 0, 3'd0, 1'b1, 5'd4, 32'h4);
    run_txn(32'h0000_000B, 32'h44, int'(T) - 1, int'(T) - 1, 1, 3'd5, 1'b1, 5'd31, 32'h1357);

    for (int n = 0; n < 40; n++) begin
      r = $urandom;
      case ($urandom_range(0, 6))
        0: op = 7'h0B;
        1: op = 7'h2B;
        2: op = 7'h5B;
        3: op = 7'h7B;
        4: op = 7'h33;
        5: op = 7'h13;
        default: op = 7'($urandom);
      endcase
      run_txn({r[31:7], op}, $urandom, $urandom_range(0, 10), $urandom_range(0, 10),
              $urandom_range(0, 4), 3'($urandom), 1'($urandom), 5'($urandom), $urandom);
    end

    // Reset while waiting for a response
    @(negedge g_clk);
    in_valid = 1'b1; in_encoded = 32'h0000_002B; in_rs1 = 32'hBEEF;
    @(negedge g_clk);
    in_valid = 1'b0;
    chk("mid_req", 32'(cpu_insn_req), 32'd1);
    cpu_insn_ack = 1'b1;
    @(negedge g_clk);
    cpu_insn_ack = 1'b0;
    chk("mid_rsp_ack", 32'(cop_insn_ack), 32'd1);
    #2 g_resetn = 1'b0;
    #1;
    chk("mid_rst_req", 32'(cpu_insn_req), 32'd0);
    chk("mid_rst_enc", cpu_insn_enc, 32'd0);
    chk("mid_rst_rs1", cpu_rs1, 32'd0);
    chk("mid_rst_cop_ack", 32'(cop_insn_ack), 32'd0);
    chk("mid_rst_wb_valid", 32'(wb_valid), 32'd0);
    @(negedge g_clk);
    g_resetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge g_clk);
      chk("post_rst_ready", 32'(in_ready), 32'd1);
      chk("post_rst_no_wb", 32'(wb_valid), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/scarv_cop_issue.md
Name: scarv_cop_issue

Overview:
- CPU-side initiator of the CPU-to-COP instruction interface.
- Accepts coprocessor instructions from the host pipeline and drives the encoded instruction and rs1 value to the coprocessor over a req/ack handshake.
- Collects the coprocessor's response (result code, optional GPR writeback) and returns it to the pipeline writeback stage.
- Handles illegal opcodes, a configurable timeout, and late responses after a timeout. At most one instruction is outstanding.

Parameters:
- TIMEOUT_CYCLES, 1023: cycles allowed in REQ or RSP before abort. Range 1..65535; the counter is 16 bits.
- CUSTOM_MASK, 4'b1111: enable bits for custom-0..3 opcodes (7'h0B, 7'h2B, 7'h5B, 7'h7B) treated as COP instructions.

Ports:
- g_clk  in  1  clock, all state on rising edge
- g_resetn  in  1  asynchronous active-low reset
- in_valid  in  1  pipeline offers an instruction
- in_ready  out  1  issuer can accept
- in_encoded  in  32  instruction word
- in_rs1  in  32  GPR rs1 value
- cpu_insn_req  out  1  request to COP
- cpu_insn_ack  in  1  COP accepts request
- cpu_insn_enc  out  32  registered instruction word
- cpu_rs1  out  32  registered rs1 value
- cop_insn_rsp  in  1  COP response valid
- cop_insn_ack  out  1  issuer accepts response
- cop_insn_result  in  3  0 = success, nonzero = exception code
- cop_wen  in  1  response carries GPR write
- cop_waddr  in  5  GPR destination
- cop_wdata  in  32  GPR data
- wb_valid  out  1  result available to pipeline
- wb_ready  in  1  pipeline consumes result
- wb_wen  out  1  write GPR
- wb_rd  out  5  GPR index
- wb_data  out  32  GPR data
- wb_result  out  3  result code; 3'b111 = timeout, 3'b110 = illegal opcode

Behaviour:
- States: IDLE, REQ, RSP, WB.
- Reset (async, g_resetn=0):
  - state=IDLE, stale=0, counter=0.
  - All registered outputs 0: cpu_insn_req, cpu_insn_enc, cpu_rs1, wb_*.
  - After reset: in_ready=1, cop_insn_ack=0.
  - Reset mid-transaction aborts it silently; no response is generated.
- in_ready = (state==IDLE) && !stale. Accept occurs when in_valid && in_ready.
- On accept:
  - Opcode in_encoded[6:0] is a COP opcode (enabled by CUSTOM_MASK): latch cpu_insn_enc/cpu_rs1, set cpu_insn_req=1, go to REQ. cpu_insn_req is high the cycle after accept.
  - Otherwise: go to WB with wb_result=3'b110, wb_wen=0, wb_data=0, wb_rd=0. No COP activity.
- REQ:
  - cpu_insn_req, cpu_insn_enc and cpu_rs1 are held stable until cpu_insn_ack=1 is sampled.
  - On ack: req drops next cycle, counter clears, go to RSP.
- RSP:
  - cop_insn_ack=1 (combinational on state).
  - On cop_insn_rsp: capture wb_result=cop_insn_result, wb_wen=cop_wen, wb_rd=cop_waddr, wb_data = cop_wen ? cop_wdata : 0. Go to WB.
  - A response arriving in the same cycle the REQ ack is sampled is not possible; cop_insn_ack is 0 in REQ.
- WB:
  - wb_valid=1 with stable payload until wb_ready. On wb_ready go to IDLE and clear wb_*.
  - Back-to-back: a new accept can occur the cycle after wb handshake.
  - Minimum latency, accept to wb_valid: 3 cycles when the COP acks and responds each in 1 cycle.
- Timeout:
  - Counter increments each cycle in REQ or RSP; it saturates and does not wrap.
  - Reaching TIMEOUT_CYCLES in REQ: deassert req, go to WB with wb_result=3'b111, wb_wen=0.
  - Reaching it in RSP: same, and set stale=1.
  - If ack or rsp coincides with the timeout cycle, ack/rsp wins and there is no timeout.
- Stale drain:
  - While stale=1 in IDLE: cop_insn_ack=1 and in_ready=0.
  - The next cop_insn_rsp is consumed and discarded; stale clears. wb is not touched.

Test Plan:
- Reset then in_encoded=32'h0000_002B, in_rs1=32'h1234, COP acks the same cycle the request appears and responds next cycle with result 0, wen=1, waddr=5, wdata=32'hDEAD_BEEF -> wb_valid with wb_rd=5, wb_data=32'hDEAD_BEEF, wb_result=0, three cycles after accept.
- in_encoded=32'h0000_0033 (OP opcode) -> wb_result=3'b110 one cycle after accept, cpu_insn_req never asserts.
- cpu_insn_ack held low 5 cycles -> cpu_insn_enc/cpu_rs1/req stable for all 6 cycles; req drops the cycle after ack.
- TIMEOUT_CYCLES=8, COP acks but never responds -> wb_result=3'b111 after 8 RSP cycles; in_ready stays 0 until a late rsp arrives, which produces no wb_valid; in_ready returns to 1 the next cycle.
- wb_ready held low 4 cycles with response wdata=32'hA5A5_A5A5, wen=0 -> wb_valid held, wb_data=0, wb_wen=0, in_ready=0 throughout.
- g_resetn pulsed low during RSP -> all outputs 0 immediately, in_ready=1 after release, no wb_valid.
